// File: rtl/rfid_access_ctrl.sv
// -----------------------------------------------------------------------------
// rfid_access_ctrl
//
// Card-permission engine fed by the reader's response byte stream. Bytes are
// assembled MSB-first into a UID, the UID is scanned against a runtime
// programmable whitelist (one entry per cycle, lowest matching index wins),
// and the result is a timed grant level or a single-cycle deny pulse.
// Consecutive denials are counted; reaching MAX_FAILS starts a lockout.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   rx_valid/ready : reader byte handshake, rx_data is the byte (MSB first)
//   wr_en/ready    : whitelist write handshake
//   wr_idx/uid/vld : entry index, UID and enable bit (vld=0 deletes)
//   valid_card     : access granted (level, GRANT_CYCLES long)
//   card_uid       : last fully assembled UID
//   match_idx      : lowest matching entry index of the last grant
//   deny           : one-cycle pulse on a denial
//   frame_err      : one-cycle pulse when a partial frame times out
//   locked         : lockout active
// -----------------------------------------------------------------------------
module rfid_access_ctrl #(
    parameter  int UID_BYTES      = 4,
    parameter  int NUM_IDS        = 8,
    parameter  int GRANT_CYCLES   = 50000,
    parameter  int BYTE_TIMEOUT   = 1000,
    parameter  int MAX_FAILS      = 3,
    parameter  int LOCKOUT_CYCLES = 1000000,
    localparam int UW             = 8 * UID_BYTES,
    localparam int IW             = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [UW-1:0] wr_uid,
    input  logic          wr_vld,
    output logic          wr_ready,
    output logic          valid_card,
    output logic [UW-1:0] card_uid,
    output logic [IW-1:0] match_idx,
    output logic          deny,
    output logic          frame_err,
    output logic          locked
);

    // Counter widths: every counter holds its terminal value without wrapping.
    localparam int BCW = $clog2(UID_BYTES + 1);
    localparam int TOW = $clog2(BYTE_TIMEOUT + 1);
    localparam int GCW = $clog2(GRANT_CYCLES + 1);
    localparam int FCW = $clog2(MAX_FAILS + 1);
    localparam int LCW = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [IW:0]   IDX_LIMIT  = (IW + 1)'(NUM_IDS);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_IDS - 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(UID_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_COMPARE,
        ST_GRANT,
        ST_DENY,
        ST_LOCKOUT
    } state_e;

    state_e          state_q;
    logic [UW-1:0]   sr_q;
    logic [BCW-1:0]  byte_cnt_q;
    logic [TOW-1:0]  idle_cnt_q;
    logic [IW-1:0]   scan_idx_q;
    logic            hit_q;
    logic [IW-1:0]   hit_idx_q;
    logic [FCW-1:0]  fail_cnt_q;
    logic [GCW-1:0]  grant_cnt_q;
    logic [LCW-1:0]  lock_cnt_q;

    logic            valid_card_q;
    logic [UW-1:0]   card_uid_q;
    logic [IW-1:0]   match_idx_q;
    logic            deny_q;
    logic            frame_err_q;
    logic            locked_q;

    // Whitelist storage: UID payload plus a per-entry enable bit.
    logic [UW-1:0]      uid_tbl [NUM_IDS];
    logic [NUM_IDS-1:0] vld_q;

    logic          accept;
    logic          wr_fire;
    logic [UW-1:0] uid_shift;
    logic          entry_hit;

    // A timed-out frame spends its frame_err cycle in COLLECT; no byte may be
    // accepted then, since the partial UID is about to be discarded.
    assign rx_ready  = (state_q == ST_IDLE) || ((state_q == ST_COLLECT) && !frame_err_q);
    assign wr_ready  = (state_q != ST_COMPARE);
    assign accept    = rx_valid && rx_ready;
    assign wr_fire   = wr_en && wr_ready && ({1'b0, wr_idx} < IDX_LIMIT);

    // New byte enters at the LSB; the oldest byte falls off the top.
    assign uid_shift = UW'({sr_q, rx_data});

    assign entry_hit = vld_q[scan_idx_q] && (uid_tbl[scan_idx_q] == card_uid_q);

    assign valid_card = valid_card_q;
    assign card_uid   = card_uid_q;
    assign match_idx  = match_idx_q;
    assign deny       = deny_q;
    assign frame_err  = frame_err_q;
    assign locked     = locked_q;

    // NOTE: the UID payload is deliberately left out of reset; clearing the
    // enable bits already empties the table, and a reset-free array maps onto
    // plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            uid_tbl[wr_idx] <= wr_uid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (wr_fire) begin
            vld_q[wr_idx] <= wr_vld;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sr_q         <= '0;
            byte_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            scan_idx_q   <= '0;
            hit_q        <= 1'b0;
            hit_idx_q    <= '0;
            fail_cnt_q   <= '0;
            grant_cnt_q  <= '0;
            lock_cnt_q   <= '0;
            valid_card_q <= 1'b0;
            card_uid_q   <= '0;
            match_idx_q  <= '0;
            deny_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            deny_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        sr_q <= UW'(rx_data);
                        if (UID_BYTES == 1) begin
                            card_uid_q <= uid_shift;
                            scan_idx_q <= '0;
                            hit_q      <= 1'b0;
                            state_q    <= ST_COMPARE;
                        end else begin
                            byte_cnt_q  <= BCW'(1);
                            idle_cnt_q  <= TOW'(1);
                            frame_err_q <= (BYTE_TIMEOUT == 1);
                            state_q     <= ST_COLLECT;
                        end
                    end
                end

                ST_COLLECT: begin
                    if (frame_err_q) begin
                        // Timeout pulse is being shown this cycle; drop the frame.
                        frame_err_q <= 1'b0;
                        sr_q        <= '0;
                        byte_cnt_q  <= '0;
                        idle_cnt_q  <= '0;
                        state_q     <= ST_IDLE;
                    end else if (accept) begin
                        sr_q       <= uid_shift;
                        idle_cnt_q <= TOW'(1);
                        if (byte_cnt_q == LAST_BYTE) begin
                            card_uid_q <= uid_shift;
                            byte_cnt_q <= '0;
                            scan_idx_q <= '0;
                            hit_q      <= 1'b0;
                            state_q    <= ST_COMPARE;
                        end else begin
                            byte_cnt_q  <= byte_cnt_q + BCW'(1);
                            frame_err_q <= (BYTE_TIMEOUT == 1);
                        end
                    end else begin
                        // idle_cnt_q counts cycles since the last accepted byte;
                        // raising frame_err one cycle early makes it visible
                        // exactly BYTE_TIMEOUT cycles after that byte.
                        idle_cnt_q  <= idle_cnt_q + TOW'(1);
                        frame_err_q <= (idle_cnt_q == TOW'(BYTE_TIMEOUT - 1));
                    end
                end

                ST_COMPARE: begin
                    if (entry_hit && !hit_q) begin
                        hit_q     <= 1'b1;
                        hit_idx_q <= scan_idx_q;
                    end
                    if (scan_idx_q == LAST_IDX) begin
                        // The last entry's compare is folded in here so the
                        // exit decision does not cost an extra cycle.
                        if (hit_q || entry_hit) begin
                            match_idx_q  <= hit_q ? hit_idx_q : scan_idx_q;
                            fail_cnt_q   <= '0;
                            valid_card_q <= 1'b1;
                            grant_cnt_q  <= GCW'(1);
                            state_q      <= ST_GRANT;
                        end else begin
                            deny_q <= 1'b1;
                            if (fail_cnt_q != FCW'(MAX_FAILS)) begin
                                fail_cnt_q <= fail_cnt_q + FCW'(1);
                            end
                            state_q <= ST_DENY;
                        end
                        hit_q      <= 1'b0;
                        scan_idx_q <= '0;
                    end else begin
                        scan_idx_q <= scan_idx_q + IW'(1);
                    end
                end

                ST_GRANT: begin
                    if (grant_cnt_q == GCW'(GRANT_CYCLES)) begin
                        valid_card_q <= 1'b0;
                        grant_cnt_q  <= '0;
                        state_q      <= ST_IDLE;
                    end else begin
                        grant_cnt_q <= grant_cnt_q + GCW'(1);
                    end
                end

                ST_DENY: begin
                    if (fail_cnt_q == FCW'(MAX_FAILS)) begin
                        locked_q   <= 1'b1;
                        lock_cnt_q <= LCW'(1);
                        state_q    <= ST_LOCKOUT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_LOCKOUT: begin
                    if (lock_cnt_q == LCW'(LOCKOUT_CYCLES)) begin
                        locked_q   <= 1'b0;
                        lock_cnt_q <= '0;
                        fail_cnt_q <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + LCW'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rfid_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rfid_access_ctrl
//
// Self-checking bench for rfid_access_ctrl with shortened timers. A reference
// model holds the whitelist as plain arrays, resolves each UID by a linear
// lowest-index search and tracks the denial count; the bench then checks the
// cycle-exact outcome (grant length, deny pulse, lockout length, timeouts).
// -----------------------------------------------------------------------------
module tb_rfid_access_ctrl;

    localparam int UID_BYTES      = 4;
    localparam int NUM_IDS        = 8;
    localparam int GRANT_CYCLES   = 20;
    localparam int BYTE_TIMEOUT   = 12;
    localparam int MAX_FAILS      = 3;
    localparam int LOCKOUT_CYCLES = 30;
    localparam int UW             = 8 * UID_BYTES;
    localparam int IW             = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_ready;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [UW-1:0] wr_uid = '0;
    logic          wr_vld = 1'b0;
    logic          wr_ready;
    logic          valid_card;
    logic [UW-1:0] card_uid;
    logic [IW-1:0] match_idx;
    logic          deny;
    logic          frame_err;
    logic          locked;

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference model state.
    logic [UW-1:0] mdl_uid [NUM_IDS];
    bit            mdl_vld [NUM_IDS];
    int            mdl_fails;
    logic [UW-1:0] mdl_card;

    always #5 clk = ~clk;

    rfid_access_ctrl #(
        .UID_BYTES      (UID_BYTES),
        .NUM_IDS        (NUM_IDS),
        .GRANT_CYCLES   (GRANT_CYCLES),
        .BYTE_TIMEOUT   (BYTE_TIMEOUT),
        .MAX_FAILS      (MAX_FAILS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_uid     (wr_uid),
        .wr_vld     (wr_vld),
        .wr_ready   (wr_ready),
        .valid_card (valid_card),
        .card_uid   (card_uid),
        .match_idx  (match_idx),
        .deny       (deny),
        .frame_err  (frame_err),
        .locked     (locked)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int mdl_lookup(input logic [UW-1:0] u);
        for (int i = 0; i < NUM_IDS; i++) begin
            if (mdl_vld[i] && mdl_uid[i] == u) return i;
        end
        return -1;
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < NUM_IDS; i++) mdl_vld[i] = 1'b0;
        mdl_fails = 0;
        mdl_card  = '0;
    endtask

    // Called at a negedge; returns at the negedge after the reset release clock.
    task automatic apply_reset(input string tag);
        rx_valid = 1'b0;
        wr_en    = 1'b0;
        rst_n    = 1'b0;
        #1;
        check({tag, "_ctl"}, {valid_card, deny, frame_err, locked}, 4'b0000);
        check({tag, "_uid"}, card_uid, '0);
        check({tag, "_midx"}, match_idx, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mdl_clear();
        @(negedge clk);
        check({tag, "_rx_ready"}, rx_ready, 1);
        check({tag, "_wr_ready"}, wr_ready, 1);
    endtask

    task automatic do_write(input int idx, input logic [UW-1:0] u, input bit v);
        check("wr_ready_idle", wr_ready, 1);
        wr_en  = 1'b1;
        wr_idx = IW'(idx);
        wr_uid = u;
        wr_vld = v;
        @(negedge clk);
        wr_en = 1'b0;
        if (idx < NUM_IDS) begin
            mdl_uid[idx] = u;
            mdl_vld[idx] = v;
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        waited   = 0;
        while (!rx_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("rx_ready_accept", rx_ready, 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [UW-1:0] u, input int max_gap);
        for (int b = UID_BYTES - 1; b >= 0; b--) begin
            send_byte(u[8*b +: 8], $urandom_range(0, max_gap));
        end
    endtask

    // Entered at T+1 (cycle after the last byte); checks the whole outcome.
    task automatic expect_outcome(input logic [UW-1:0] u, input bit wr_during);
        int exp_idx;
        int cnt;
        bit early_bad;
        bit stall_bad;
        exp_idx = mdl_lookup(u);
        mdl_card = u;
        check("card_uid", card_uid, u);
        check("rx_ready_cmp", rx_ready, 0);
        check("wr_ready_cmp", wr_ready, 0);
        if (wr_during) begin
            // A write that leaked through would flip this scan's outcome.
            wr_en  = 1'b1;
            wr_idx = IW'((exp_idx >= 0) ? exp_idx : 0);
            wr_uid = u;
            wr_vld = (exp_idx < 0);
        end
        early_bad = 1'b0;
        for (int i = 2; i <= NUM_IDS + 1; i++) begin
            @(negedge clk);
            if (i == NUM_IDS) wr_en = 1'b0;
            if (i <= NUM_IDS && (valid_card || deny)) early_bad = 1'b1;
        end
        check("early_result", early_bad, 0);
        stall_bad = 1'b0;
        if (exp_idx >= 0) begin
            check("valid_card", valid_card, 1);
            check("match_idx", match_idx, exp_idx);
            check("deny_on_grant", deny, 0);
            mdl_fails = 0;
            cnt = 0;
            while (valid_card && cnt < GRANT_CYCLES + 5) begin
                if (rx_ready) stall_bad = 1'b1;
                cnt++;
                @(negedge clk);
            end
            check("grant_len", cnt, GRANT_CYCLES);
            check("grant_stall", stall_bad, 0);
            check("rx_ready_post_grant", rx_ready, 1);
        end else begin
            check("deny", deny, 1);
            check("valid_on_deny", valid_card, 0);
            if (mdl_fails < MAX_FAILS) mdl_fails++;
            @(negedge clk);
            check("deny_pulse_end", deny, 0);
            if (mdl_fails == MAX_FAILS) begin
                cnt = 0;
                while (locked && cnt < LOCKOUT_CYCLES + 5) begin
                    if (rx_ready) stall_bad = 1'b1;
                    cnt++;
                    @(negedge clk);
                end
                check("lock_len", cnt, LOCKOUT_CYCLES);
                check("lock_stall", stall_bad, 0);
                check("rx_ready_post_lock", rx_ready, 1);
                mdl_fails = 0;
            end else begin
                check("locked", locked, 0);
                check("rx_ready_post_deny", rx_ready, 1);
            end
        end
    endtask

    task automatic frame(input logic [UW-1:0] u);
        send_frame(u, 3);
        expect_outcome(u, 1'b0);
    endtask

    task automatic random_write();
        int idx;
        int src;
        logic [UW-1:0] u;
        idx = $urandom_range(0, NUM_IDS - 1);
        src = $urandom_range(0, NUM_IDS - 1);
        u   = ($urandom_range(0, 2) == 0 && mdl_vld[src]) ? mdl_uid[src] : UW'($urandom);
        do_write(idx, u, $urandom_range(0, 3) != 0);
    endtask

    function automatic logic [UW-1:0] pick_uid();
        int valid_list[$];
        for (int i = 0; i < NUM_IDS; i++) if (mdl_vld[i]) valid_list.push_back(i);
        if (valid_list.size() > 0 && $urandom_range(0, 2) != 0)
            return mdl_uid[valid_list[$urandom_range(0, valid_list.size() - 1)]];
        return UW'($urandom);
    endfunction

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_err;
        int err_pulses;
        bit deny_seen;
        logic [UW-1:0] u;

        mdl_clear();
        #1;
        apply_reset("rst_init");

        // Single entry grant with full timing checks.
        do_write(2, 32'hB364DE05, 1'b1);
        frame(32'hB364DE05);

        // Duplicate entries: the lowest index wins; deleting it exposes the next.
        do_write(1, 32'h01234567, 1'b1);
        do_write(5, 32'h01234567, 1'b1);
        frame(32'h01234567);
        do_write(1, 32'h01234567, 1'b0);
        frame(32'h01234567);

        // Three unknown cards trigger lockout; a valid card is granted after.
        repeat (3) frame(32'hDEADBEEF);
        frame(32'hB364DE05);

        // Partial frame timeout.
        send_byte(8'hB3, 0);
        send_byte(8'h64, 0);
        first_err  = -1;
        err_pulses = 0;
        deny_seen  = 1'b0;
        for (int k = 1; k <= BYTE_TIMEOUT + 3; k++) begin
            if (frame_err) begin
                err_pulses++;
                if (first_err < 0) first_err = k;
            end
            if (deny) deny_seen = 1'b1;
            @(negedge clk);
        end
        check("timeout_at", first_err, BYTE_TIMEOUT);
        check("timeout_pulses", err_pulses, 1);
        check("timeout_no_deny", deny_seen, 0);
        check("timeout_card_uid", card_uid, mdl_card);
        check("timeout_rx_ready", rx_ready, 1);
        frame(32'hB364DE05);

        // Writes attempted during the scan must be blocked.
        send_frame(32'hB364DE05, 2);
        expect_outcome(32'hB364DE05, 1'b1);
        send_frame(32'hCAFEF00D, 2);
        expect_outcome(32'hCAFEF00D, 1'b1);
        frame(32'hB364DE05);

        // A grant in between clears the failure history.
        frame(32'h11112222);
        frame(32'h33334444);
        frame(32'h01234567);
        frame(32'h55556666);
        frame(32'h77778888);
        check("no_lockout_after_grant", locked, 0);
        mdl_fails = 0;
        frame(32'h01234567);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) random_write();
            u = pick_uid();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_frame(u, 3);
            expect_outcome(u, $urandom_range(0, 3) == 0);
        end

        // Reset mid-frame: table empties, the former valid card is denied.
        send_byte(8'hB3, 0);
        send_byte(8'h64, 1);
        apply_reset("rst_collect");
        frame(32'hB364DE05);

        // Reset mid-grant.
        do_write(2, 32'hB364DE05, 1'b1);
        send_frame(32'hB364DE05, 1);
        repeat (NUM_IDS + 3) @(negedge clk);
        check("grant_before_reset", valid_card, 1);
        apply_reset("rst_grant");
        frame(32'hB364DE05);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/rfid_access_ctrl.md
# rfid_access_ctrl

Parametrised card-permission engine behind the CR95HF SPI link. Assembles a UID of `UID_BYTES` bytes from the reader's response byte stream and scans a runtime-programmable whitelist of `NUM_IDS` entries. Produces a timed grant or a deny pulse, and enforces a lockout after repeated denials. Sits between the SPI controller's rx byte output and the firewall's unlock logic.

## Interface
- `UID_BYTES`, 4: bytes per UID; UID width `UW = 8*UID_BYTES`.
- `NUM_IDS`, 8: whitelist entries; `IW = max(1, clog2(NUM_IDS))`.
- `GRANT_CYCLES`, 50000: cycles `valid_card` is held high after a match (≥1).
- `BYTE_TIMEOUT`, 1000: maximum idle cycles between bytes of one frame (≥1).
- `MAX_FAILS`, 3: consecutive denials that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, 1000000: lockout duration (≥1).

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: reader response byte is valid.
- `rx_data` in 8: reader response byte; the first byte is the UID MSB.
- `rx_ready` out 1: a byte is accepted when `rx_valid && rx_ready`.
- `wr_en` in 1: whitelist write strobe; honoured only when `wr_ready`.
- `wr_idx` in IW: entry index; writes with `wr_idx ≥ NUM_IDS` are ignored.
- `wr_uid` in UW: UID stored in the entry.
- `wr_vld` in 1: entry-enable bit written with the UID (0 deletes the entry).
- `wr_ready` out 1: whitelist writable.
- `valid_card` out 1: access granted (level signal).
- `card_uid` out UW: last fully assembled UID.
- `match_idx` out IW: lowest matching entry index from the last grant.
- `deny` out 1: one-cycle pulse on a denial.
- `frame_err` out 1: one-cycle pulse when a partial frame is dropped on timeout.
- `locked` out 1: lockout active.

## Operation
- States: IDLE, COLLECT, COMPARE, GRANT, DENY, LOCKOUT.
- `rx_ready` = 1 only in IDLE and COLLECT. `wr_ready` = 0 only in COMPARE, so writes never race the scan.
- IDLE: an accepted byte loads the shift register, sets byte count = 1 and goes to COLLECT. If `UID_BYTES` = 1, it goes straight to COMPARE.
- COLLECT: each accepted byte shifts in at the LSB: `sr <= {sr[UW-9:0], rx_data}`. When the `UID_BYTES`-th byte is accepted:
  - `card_uid <= {sr[UW-9:0], rx_data}`;
  - the FSM goes to COMPARE.
- COLLECT timeout: an idle counter resets on each accepted byte. If it reaches `BYTE_TIMEOUT`:
  - pulse `frame_err`, discard the partial UID, return to IDLE;
  - `card_uid` and the fail counter are unchanged.
- COMPARE scan: one entry per cycle, index 0 to `NUM_IDS-1`. An entry hits when its enable bit is set and its UID equals `card_uid`. The first hit latches `hit=1` and records the index; later hits are ignored (lowest index wins).
- COMPARE exit, after the last index:
  - `hit=1`: go to GRANT. Load `match_idx`, clear the fail counter, set `valid_card=1`.
  - `hit=0`: go to DENY and increment the fail counter, saturating at `MAX_FAILS`.
- GRANT: `valid_card` stays high for exactly `GRANT_CYCLES` cycles, then clears, and the FSM returns to IDLE. Incoming bytes are stalled (`rx_ready=0`).
- DENY: `deny=1` for this single cycle.
  - If the fail count is now `MAX_FAILS`, go to LOCKOUT.
  - Otherwise go to IDLE.
- LOCKOUT: `locked=1` for `LOCKOUT_CYCLES` cycles. On exit the fail counter clears and the FSM goes to IDLE.
- Whitelist writes:
  - take effect the cycle after `wr_en && wr_ready`;
  - are allowed in IDLE, COLLECT, GRANT, DENY and LOCKOUT;
  - do not alter an already-latched `valid_card` or `match_idx`.
- Reset (asynchronous, any state, including mid-frame or mid-scan):
  - state returns to IDLE;
  - all whitelist enable bits are cleared (table empty), as are the shift register, all counters and `hit`;
  - every output resets to 0: `valid_card`, `deny`, `frame_err`, `locked`, `card_uid`, `match_idx`;
  - `rx_ready=1` and `wr_ready=1` from the first clock after release.

## Timing
- Let T be the cycle the last UID byte is accepted. COMPARE occupies T+1 to T+NUM_IDS. `valid_card` rises, or `deny` pulses, at T+NUM_IDS+1. `card_uid` is valid from T+1.
- Grant latency is fixed at `NUM_IDS+1` cycles, independent of which entry matched.
- `valid_card` is high from T+NUM_IDS+1 to T+NUM_IDS+GRANT_CYCLES inclusive. `rx_ready` returns to 1 on the following cycle.
- After a non-lockout deny at T+NUM_IDS+1, `rx_ready=1` from T+NUM_IDS+2.
- After a lockout-triggering deny, `locked` is high from T+NUM_IDS+2 for `LOCKOUT_CYCLES` cycles.
- Timeout: with the last byte accepted at cycle S and no further bytes, `frame_err` pulses at S+BYTE_TIMEOUT. IDLE is reached the next cycle.
- Counters are sized with `clog2(param+1)` bits and never wrap.

## Test plan
- Program entry 2 = 0xB364DE05 with `wr_vld=1`, then stream bytes B3,64,DE,05 → `card_uid`=0xB364DE05 at T+1, `valid_card` high from T+9 for exactly 50000 cycles, `match_idx`=2, `deny`=0.
- Program entries 1 and 5 both = 0x01234567, send that UID → `match_idx`=1. Delete entry 1 (`wr_vld=0`) and resend → `match_idx`=5.
- Send an unknown UID 0xDEADBEEF three times → `deny` pulses at each T+9, fail count reaches 3, `locked`=1 and `rx_ready`=0 for 1000000 cycles. The next valid UID is then granted.
- Send 2 bytes, then idle 1000 cycles → `frame_err` pulse at S+1000, no `deny`, `card_uid` unchanged. A following full valid frame is granted.
- Assert `wr_en` during COMPARE → `wr_ready`=0 and the table is unchanged. Assert `rst_n`=0 mid-COLLECT and mid-GRANT → all outputs 0 immediately, the table is empty, and a previously valid UID is denied.
- Deny twice, grant once, deny twice → no lockout, because a grant clears the fail counter.
